// File: rtl/gray_to_rgb_pkg.sv
// Shared image parameters for the gray-to-RGB pipeline: frame geometry,
// pixel-counter sizing and RGB byte-field placement.
package gray_to_rgb_pkg;

   localparam int unsigned IMG_WIDTH  = 720;
   localparam int unsigned IMG_HEIGHT = 540;

   localparam int unsigned R_LSB = 16;
   localparam int unsigned G_LSB = 8;
   localparam int unsigned B_LSB = 0;

   typedef logic [7:0]  gray_t;
   typedef logic [23:0] rgb_t;

   // A one-pixel frame still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n_pix);
      return (n_pix > 1) ? $clog2(n_pix) : 1;
   endfunction

   localparam int unsigned PIX_CNT_W = cnt_width(IMG_WIDTH * IMG_HEIGHT);

   function automatic rgb_t gray2rgb(input gray_t g);
      rgb_t c;
      c            = '0;
      c[R_LSB +: 8] = g;
      c[G_LSB +: 8] = g;
      c[B_LSB +: 8] = g;
      return c;
   endfunction

endpackage

// File: rtl/gray_to_rgb_if.sv
// Upstream gray FIFO pop side, downstream RGB FIFO push side and frame marker.
interface gray_to_rgb_if;
   import gray_to_rgb_pkg::*;

   logic  in_rd_en;
   logic  in_empty;
   gray_t in_dout;
   logic  out_wr_en;
   logic  out_full;
   rgb_t  out_din;
   logic  frame_done;

   // Environment side: owns both FIFOs.
   modport master (
      output in_empty, in_dout, out_full,
      input  in_rd_en, out_wr_en, out_din, frame_done
   );

   // Converter side.
   modport slave (
      input  in_empty, in_dout, out_full,
      output in_rd_en, out_wr_en, out_din, frame_done
   );

endinterface

// File: rtl/gray_to_rgb.sv
// Gray-to-RGB converter: one-pixel holding stage between a FWFT gray FIFO and
// an RGB FIFO, with a per-frame pixel counter that pulses frame_done.
module gray_to_rgb
   import gray_to_rgb_pkg::*;
#(
   parameter int WIDTH  = IMG_WIDTH,
   parameter int HEIGHT = IMG_HEIGHT
) (
   input  logic         clock,
   input  logic         reset,
   gray_to_rgb_if.slave bus
);

   localparam int unsigned NPIX  = WIDTH * HEIGHT;
   localparam int unsigned CNT_W = cnt_width(NPIX);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]       r_state;
   gray_t            r_hold;
   logic [CNT_W-1:0] r_cnt;

   logic w_pop;
   logic w_push;
   logic w_last;

   // Handshakes are gated by reset so nothing moves while it is held.
   always_comb begin
      w_pop  = ~reset & ~bus.in_empty & ((r_state == S_EMPTY) | ~bus.out_full);
      w_push = ~reset & (r_state == S_FULL) & ~bus.out_full;
      w_last = w_push & (r_cnt == LAST_PIX);

      bus.in_rd_en   = w_pop;
      bus.out_wr_en  = w_push;
      bus.out_din    = gray2rgb(r_hold);
      bus.frame_done = w_last;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_hold  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_pop) begin
            r_hold  <= bus.in_dout;
            r_state <= S_FULL;
         end else if (w_push) begin
            r_state <= S_EMPTY;
         end

         if (w_push) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

endmodule
